// File: rtl/fighter_fsm.sv
// fighter_fsm: per-player fighter state machine driven once per video frame
module fighter_fsm #(
    parameter logic [9:0] START_X   = 10'd100,
    parameter logic [9:0] Y_POS     = 10'd240,
    parameter logic [9:0] X_MAX     = 10'd576,
    parameter int         STEP_FWD  = 3,
    parameter int         STEP_BACK = 2,
    parameter int         N_START   = 5,
    parameter int         N_ACTIVE  = 2,
    parameter int         N_RECOV   = 16,
    parameter int         D_START   = 4,
    parameter int         D_ACTIVE  = 3,
    parameter int         D_RECOV   = 15,
    parameter int         HITSTUN   = 20,
    parameter int         BLOCKSTUN = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       player_num,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       hit_in,
    input  logic [9:0] opp_x,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] state,
    output logic       attacking,
    output logic       dir_attacking
);
    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_BACK, S_HIT, S_BLOCK, S_START, S_ACT, S_REC
    } state_t;

    // Timed states load N-1 so that the exit tick is the one that sees zero
    localparam logic [4:0] NS_L = 5'(N_START - 1);
    localparam logic [4:0] NA_L = 5'(N_ACTIVE - 1);
    localparam logic [4:0] NR_L = 5'(N_RECOV - 1);
    localparam logic [4:0] DS_L = 5'(D_START - 1);
    localparam logic [4:0] DA_L = 5'(D_ACTIVE - 1);
    localparam logic [4:0] DR_L = 5'(D_RECOV - 1);
    localparam logic [4:0] HS_L = 5'(HITSTUN - 1);
    localparam logic [4:0] BS_L = 5'(BLOCKSTUN - 1);
    localparam logic signed [10:0] SF = 11'(STEP_FWD);
    localparam logic signed [10:0] SB = 11'(STEP_BACK);
    localparam logic signed [10:0] XM = $signed({1'b0, X_MAX});

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              typ_q, typ_d;
    logic [9:0]        x_q, x_d, x_step;
    logic              btn_q, atk_pend_q, hit_pend_q;
    logic              attacking_q, attacking_d, dir_attacking_q, dir_attacking_d;
    logic              l_only, r_only, fwd, back, atk_rise, in_atk;
    logic signed [10:0] xs, lim, xl;

    assign l_only   = btn_left & ~btn_right;
    assign r_only   = btn_right & ~btn_left;
    assign fwd      = player_num ? l_only : r_only;
    assign back     = player_num ? r_only : l_only;
    assign atk_rise = btn_attack & ~btn_q;

    // One walking step toward/away from the opponent, held off the opponent's hurtbox and the screen edges
    always_comb begin
        xs     = $signed({1'b0, x_q}) + (((fwd ^ player_num) ? 11'sd1 : -11'sd1) * (fwd ? SF : SB));
        lim    = player_num ? $signed({1'b0, opp_x}) + 11'sd64 : $signed({1'b0, opp_x}) - 11'sd64;
        xl     = ((!player_num && xs > lim) || (player_num && xs < lim)) ? lim : xs;
        x_step = (xl < 0) ? 10'd0 : (xl > XM) ? X_MAX : xl[9:0];
    end

    // Per-frame transition: hit beats attack beats movement
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        typ_d   = typ_q;
        x_d     = x_q;
        if (frame_tick) begin
            case (state_q)
                S_IDLE, S_FWD, S_BACK: begin
                    if (hit_pend_q) begin
                        state_d = back ? S_BLOCK : S_HIT;
                        cnt_d   = back ? BS_L : HS_L;
                    end else if (atk_pend_q) begin
                        state_d = S_START;
                        typ_d   = fwd;
                        cnt_d   = fwd ? DS_L : NS_L;
                    end else if (fwd || back) begin
                        state_d = fwd ? S_FWD : S_BACK;
                        x_d     = x_step;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START, S_ACT, S_REC: begin
                    if (hit_pend_q) begin
                        state_d = S_HIT;
                        cnt_d   = HS_L;
                    end else if (cnt_q == 5'd0) begin
                        state_d = (state_q == S_START) ? S_ACT : (state_q == S_ACT) ? S_REC : S_IDLE;
                        cnt_d   = (state_q == S_START) ? (typ_q ? DA_L : NA_L) : (typ_q ? DR_L : NR_L);
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_d = (cnt_q == 5'd0) ? S_IDLE : state_q;
                    cnt_d   = cnt_q - 5'd1;
                end
            endcase
        end
        in_atk          = state_d inside {S_START, S_ACT, S_REC};
        attacking_d     = in_atk & ~typ_d;
        dir_attacking_d = in_atk & typ_d;
    end

    // State, position and edge-captured request flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= 5'd0;
            typ_q           <= 1'b0;
            x_q             <= START_X;
            btn_q           <= 1'b0;
            atk_pend_q      <= 1'b0;
            hit_pend_q      <= 1'b0;
            attacking_q     <= 1'b0;
            dir_attacking_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            typ_q           <= typ_d;
            x_q             <= x_d;
            btn_q           <= btn_attack;
            atk_pend_q      <= frame_tick ? atk_rise : (atk_pend_q | atk_rise);
            hit_pend_q      <= frame_tick ? hit_in : (hit_pend_q | hit_in);
            attacking_q     <= attacking_d;
            dir_attacking_q <= dir_attacking_d;
        end
    end

    assign x_pos         = x_q;
    assign y_pos         = Y_POS;
    assign state         = state_q;
    assign attacking     = attacking_q;
    assign dir_attacking = dir_attacking_q;
endmodule

// File: tb/tb_fighter_fsm.sv
// tb_fighter_fsm: directed and randomized check of fighter_fsm against a frame-level model
module tb_fighter_fsm;
    logic       clk = 0, rst = 1, frame_tick = 0, player_num = 0;
    logic       btn_left = 0, btn_right = 0, btn_attack = 0, hit_in = 0;
    logic [9:0] opp_x = 10'd400;
    logic [9:0] x_pos, y_pos;
    logic [2:0] state;
    logic       attacking, dir_attacking;
    int         vectors = 0, miscompares = 0;
    bit         chk_en = 0;

    fighter_fsm dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .player_num(player_num),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .hit_in(hit_in), .opp_x(opp_x), .x_pos(x_pos), .y_pos(y_pos),
        .state(state), .attacking(attacking), .dir_attacking(dir_attacking)
    );

    always #5 clk = ~clk;

    // Model: state code as shown on the output, frames left in the current timed state
    int m_st, m_rem, m_x;
    bit m_dir, m_ap, m_hp, m_btn;

    task automatic model_tick();
        bit l, r, f, b;
        int nx;
        l = btn_left && !btn_right;
        r = btn_right && !btn_left;
        f = player_num ? l : r;
        b = player_num ? r : l;
        if (m_st <= 2) begin
            if (m_hp) begin
                m_st  = b ? 4 : 3;
                m_rem = b ? 15 : 20;
            end else if (m_ap) begin
                m_st  = 5;
                m_dir = f;
                m_rem = f ? 4 : 5;
            end else if (f || b) begin
                m_st = f ? 1 : 2;
                nx   = m_x + (f ? 3 : -2) * (player_num ? -1 : 1);
                if (!player_num && nx > int'(opp_x) - 64) nx = int'(opp_x) - 64;
                if (player_num && nx < int'(opp_x) + 64) nx = int'(opp_x) + 64;
                m_x = nx < 0 ? 0 : nx > 576 ? 576 : nx;
            end else begin
                m_st = 0;
            end
        end else if (m_st >= 5) begin
            if (m_hp) begin
                m_st  = 3;
                m_rem = 20;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_st == 5) begin
                        m_st  = 6;
                        m_rem = m_dir ? 3 : 2;
                    end else if (m_st == 6) begin
                        m_st  = 7;
                        m_rem = m_dir ? 15 : 16;
                    end else begin
                        m_st = 0;
                    end
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_st = 0;
        end
    endtask

    initial forever begin
        bit rise;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = 0; m_rem = 0; m_x = 100; m_dir = 0; m_ap = 0; m_hp = 0; m_btn = 0;
        end else begin
            rise  = btn_attack && !m_btn;
            m_btn = btn_attack;
            if (frame_tick) begin
                model_tick();
                m_ap = rise;
                m_hp = hit_in;
            end else begin
                m_ap = m_ap | rise;
                m_hp = m_hp | hit_in;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("x_pos", x_pos, m_x);
            check("y_pos", y_pos, 240);
            check("state", state, m_st);
            check("attacking", attacking, (m_st >= 5 && !m_dir) ? 1 : 0);
            check("dir_attacking", dir_attacking, (m_st >= 5 && m_dir) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1;
            @(negedge clk) frame_tick = 0;
        end
    endtask

    task automatic tap();
        @(negedge clk) btn_attack = 1;
        @(negedge clk) btn_attack = 0;
    endtask

    task automatic hit();
        @(negedge clk) hit_in = 1;
        @(negedge clk) hit_in = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;
        check("rst_x", x_pos, 100);
        check("rst_y", y_pos, 240);
        check("rst_state", state, 0);
        check("rst_atk", attacking, 0);
        check("rst_dir", dir_attacking, 0);
        btn_right = 1;
        tick(10);
        check("walk_state", state, 1);
        check("walk_x", x_pos, 130);
        btn_right = 0;
        tick(1);
        check("release_state", state, 0);
        tap();
        tick(1);
        check("n_start", state, 5);
        check("n_atk", attacking, 1);
        tick(4);
        check("n_start_end", state, 5);
        tick(1);
        check("n_active", state, 6);
        tick(1);
        check("n_active_end", state, 6);
        tick(1);
        check("n_recov", state, 7);
        tick(15);
        check("n_recov_end", state, 7);
        check("n_atk_end", attacking, 1);
        tick(1);
        check("n_done", state, 0);
        check("n_atk_off", attacking, 0);
        player_num = 1;
        opp_x = 10'd0;
        @(negedge clk) begin btn_left = 1; btn_attack = 1; end
        @(negedge clk) btn_attack = 0;
        tick(1);
        btn_left = 0;
        check("d_start", state, 5);
        check("d_dir", dir_attacking, 1);
        check("d_natk", attacking, 0);
        tick(3);
        check("d_start_end", state, 5);
        tick(1);
        check("d_active", state, 6);
        tick(2);
        check("d_active_end", state, 6);
        tick(1);
        check("d_recov", state, 7);
        tick(14);
        check("d_recov_end", state, 7);
        check("d_x", x_pos, 130);
        tick(1);
        check("d_done", state, 0);
        player_num = 0;
        opp_x = 10'd400;
        tap();
        tick(6);
        check("pre_hit", state, 6);
        hit();
        tick(1);
        check("hitstun", state, 3);
        check("hit_atk_off", attacking, 0);
        tick(19);
        check("hitstun_end", state, 3);
        tick(1);
        check("hitstun_done", state, 0);
        btn_left = 1;
        hit();
        tick(1);
        check("blockstun", state, 4);
        tick(14);
        check("blockstun_end", state, 4);
        tick(1);
        check("blockstun_done", state, 0);
        btn_left = 0;
        btn_right = 1;
        tick(80);
        check("overlap_x", x_pos, 336);
        btn_right = 0;
        btn_left = 1;
        tick(200);
        check("left_edge", x_pos, 0);
        btn_left = 0;
        btn_right = 1;
        tick(1);
        check("odd_x", x_pos, 3);
        btn_right = 0;
        btn_left = 1;
        tick(1);
        check("odd_x1", x_pos, 1);
        tick(1);
        check("no_wrap", x_pos, 0);
        btn_left = 0;
        tap();
        tick(8);
        check("mid_recov", state, 7);
        @(negedge clk) #1 rst = 1;
        #1;
        check("arst_state", state, 0);
        check("arst_x", x_pos, 100);
        check("arst_atk", attacking, 0);
        @(negedge clk) rst = 0;
        repeat (20000) begin
            @(negedge clk);
            frame_tick = ($urandom_range(0, 2) == 0);
            hit_in     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 11) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 11) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 5) == 0) btn_attack = ~btn_attack;
            if ($urandom_range(0, 199) == 0) opp_x = 10'($urandom_range(0, 576));
            if ($urandom_range(0, 499) == 0) player_num = ~player_num;
            #1 rst = ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
